prbs_gen_chk: RTL

Parametrised PRBS generator and self-synchronising checker for link bring-up and BER test. Polynomial is selectable at run time and W bits are produced or checked per clock. The generator drives a valid/ready stream toward the serializer or DUT. The checker consumes a received word stream, acquires lock, and counts bit errors.

---
 rtl/prbs_pkg.sv | 88 ++++++++
 rtl/prbs_lfsr_step.sv | 35 +++
 rtl/prbs_gen_chk.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs_pkg                                                             |
// | Mode encodings, polynomial lookup and W-step LFSR advance function.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package prbs_pkg;

   localparam logic [2:0] c_MODE_PRBS7  = 3'd0;
   localparam logic [2:0] c_MODE_PRBS9  = 3'd1;
   localparam logic [2:0] c_MODE_PRBS15 = 3'd2;
   localparam logic [2:0] c_MODE_PRBS23 = 3'd3;
   localparam logic [2:0] c_MODE_PRBS31 = 3'd4;

   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } chk_state_t;

   typedef struct packed {
      logic [30:0] state;
      logic [31:0] out;
      logic [31:0] fb;
   } prbs_adv_t;

   function automatic logic [4:0] prbs_len(input logic [2:0] mode);
      case (mode)
         c_MODE_PRBS9:  return 5'd9;
         c_MODE_PRBS15: return 5'd15;
         c_MODE_PRBS23: return 5'd23;
         c_MODE_PRBS31: return 5'd31;
         default:       return 5'd7;
      endcase
   endfunction

   function automatic logic [4:0] prbs_tap(input logic [2:0] mode);
      case (mode)
         c_MODE_PRBS9:  return 5'd5;
         c_MODE_PRBS15: return 5'd14;
         c_MODE_PRBS23: return 5'd18;
         c_MODE_PRBS31: return 5'd28;
         default:       return 5'd6;
      endcase
   endfunction

   function automatic logic [30:0] prbs_mask(input logic [4:0] len);
      logic [30:0] m;
      m = '0;
      for (int i = 0; i < 31; i++) begin
         if (i < int'(len)) m[i] = 1'b1;
      end
      return m;
   endfunction

   // out collects r[N-1] per step (generator view); fb collects the feedback
   // bit, which is the prediction of the next bit when the state holds history.
   function automatic prbs_adv_t prbs_advance(
      input logic [30:0] state,
      input logic [4:0]  len,
      input logic [4:0]  tap,
      input int          steps,
      input logic [31:0] ext,
      input logic        use_ext
   );
      prbs_adv_t   r;
      logic [30:0] st;
      logic        ob;
      logic        fbb;
      logic        ib;
      st    = state;
      r.out = '0;
      r.fb  = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < steps) begin
            ob    = st[len - 5'd1];
            fbb   = ob ^ st[tap - 5'd1];
            ib    = use_ext ? ext[steps - 1 - i] : fbb;
            st    = {st[29:0], ib} & prbs_mask(len);
            r.out = {r.out[30:0], ob};
            r.fb  = {r.fb[30:0], fbb};
         end
      end
      r.state = st;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs_lfsr_step                                                       |
// | Combinational W-step advance of a 31-bit LFSR with selectable taps.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prbs_lfsr_step
   import prbs_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [30:0]  state_i,
   input  logic [4:0]   len_i,
   input  logic [4:0]   tap_i,
   input  logic [W-1:0] ext_i,
   input  logic         use_ext_i,
   output logic [30:0]  next_o,
   output logic [W-1:0] out_o,
   output logic [W-1:0] fb_o
);

   prbs_adv_t w_adv;
   logic      w_unused_hi;

   always_comb begin
      w_adv = prbs_advance(state_i, len_i, tap_i, W, 32'(ext_i), use_ext_i);
   end

   assign next_o      = w_adv.state;
   assign out_o       = w_adv.out[W-1:0];
   assign fb_o        = w_adv.fb[W-1:0];
   assign w_unused_hi = ^{w_adv.out, w_adv.fb};

endmodule
`default_nettype wire

// File: rtl/prbs_gen_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs_gen_chk                                                         |
// | PRBS word generator with valid/ready output and self-sync checker.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prbs_gen_chk
   import prbs_pkg::*;
#(
   parameter int W            = 8,
   parameter int CNT_W        = 32,
   parameter int LOCK_WORDS   = 8,
   parameter int UNLOCK_WORDS = 4,
   parameter int DEF_MODE     = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [2:0]       mode_i,
   input  logic [30:0]      seed_i,
   input  logic             load_i,
   input  logic             gen_en_i,
   input  logic             inj_err_i,
   output logic [W-1:0]     tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   input  logic [W-1:0]     rx_data_i,
   input  logic             rx_valid_i,
   input  logic             chk_en_i,
   input  logic             err_clr_i,
   output logic             lock_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam int c_PC_W  = $clog2(W + 1);
   localparam int c_LCK_W = $clog2(LOCK_WORDS + 1);
   localparam int c_ULK_W = $clog2(UNLOCK_WORDS + 1);

   logic [2:0]         r_mode;
   logic [30:0]        r_gen_lfsr;
   logic [30:0]        r_chk_lfsr;
   logic               r_inj_pend;
   logic [W-1:0]       r_tx_data;
   logic               r_tx_valid;
   chk_state_t         r_chk_state;
   logic [c_LCK_W-1:0] r_clean_cnt;
   logic [c_ULK_W-1:0] r_bad_cnt;
   logic               r_lock;
   logic               r_err;
   logic [CNT_W-1:0]   r_err_cnt;

   logic [4:0]         w_len;
   logic [4:0]         w_tap;
   logic [30:0]        w_seed_mask;
   logic [30:0]        w_seed;
   logic [30:0]        w_gen_next;
   logic [30:0]        w_chk_next;
   logic [W-1:0]       w_gen_word;
   logic [W-1:0]       w_pred;
   logic [W-1:0]       w_mism;
   logic [W-1:0]       w_unused_gen_fb;
   logic [W-1:0]       w_unused_chk_out;
   logic [c_PC_W-1:0]  w_nerr;
   logic               w_adv;
   logic               w_chk_act;
   logic [CNT_W:0]     w_sum;
   logic [CNT_W-1:0]   w_sat;

   assign w_len       = prbs_len(r_mode);
   assign w_tap       = prbs_tap(r_mode);
   assign w_seed_mask = prbs_mask(prbs_len(mode_i));
   assign w_seed      = seed_i & w_seed_mask;
   assign w_adv       = gen_en_i && (!r_tx_valid || tx_ready_i);
   assign w_chk_act   = rx_valid_i && chk_en_i;

   prbs_lfsr_step #(.W(W)) u_gen_step (
      .state_i   (r_gen_lfsr),
      .len_i     (w_len),
      .tap_i     (w_tap),
      .ext_i     ('0),
      .use_ext_i (1'b0),
      .next_o    (w_gen_next),
      .out_o     (w_gen_word),
      .fb_o      (w_unused_gen_fb)
   );

   // While unlocked the checker state is fed with received bits so it
   // converges to the last N bits on the line.
   prbs_lfsr_step #(.W(W)) u_chk_step (
      .state_i   (r_chk_lfsr),
      .len_i     (w_len),
      .tap_i     (w_tap),
      .ext_i     (rx_data_i),
      .use_ext_i (r_chk_state == ST_UNLOCKED),
      .next_o    (w_chk_next),
      .out_o     (w_unused_chk_out),
      .fb_o      (w_pred)
   );

   assign w_mism = rx_data_i ^ w_pred;

   always_comb begin
      w_nerr = '0;
      for (int i = 0; i < W; i++) begin
         w_nerr = w_nerr + c_PC_W'(w_mism[i]);
      end
   end

   assign w_sum = {1'b0, r_err_cnt} + (CNT_W + 1)'(w_nerr);
   assign w_sat = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_mode     <= 3'(DEF_MODE);
         r_gen_lfsr <= prbs_mask(prbs_len(3'(DEF_MODE)));
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_inj_pend <= 1'b0;
      end else if (load_i) begin
         r_mode     <= mode_i;
         r_gen_lfsr <= (w_seed == '0) ? w_seed_mask : w_seed;
         r_tx_valid <= 1'b0;
         r_inj_pend <= r_inj_pend | inj_err_i;
      end else if (w_adv) begin
         r_tx_data  <= w_gen_word ^ W'(r_inj_pend);
         r_tx_valid <= 1'b1;
         r_gen_lfsr <= w_gen_next;
         r_inj_pend <= inj_err_i;
      end else begin
         if (tx_ready_i) r_tx_valid <= 1'b0;
         r_inj_pend <= r_inj_pend | inj_err_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_chk_state <= ST_UNLOCKED;
         r_chk_lfsr  <= '0;
         r_clean_cnt <= '0;
         r_bad_cnt   <= '0;
         r_lock      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (load_i) begin
            r_chk_state <= ST_UNLOCKED;
            r_chk_lfsr  <= '0;
            r_clean_cnt <= '0;
            r_bad_cnt   <= '0;
            r_lock      <= 1'b0;
         end else if (w_chk_act) begin
            r_chk_lfsr <= w_chk_next;
            case (r_chk_state)
               ST_UNLOCKED: begin
                  if (w_mism != '0) begin
                     r_clean_cnt <= '0;
                  end else if (r_clean_cnt == c_LCK_W'(LOCK_WORDS - 1)) begin
                     r_chk_state <= ST_LOCKED;
                     r_lock      <= 1'b1;
                     r_clean_cnt <= '0;
                     r_bad_cnt   <= '0;
                  end else begin
                     r_clean_cnt <= r_clean_cnt + 1'b1;
                  end
               end
               default: begin
                  if (w_mism == '0) begin
                     r_bad_cnt <= '0;
                  end else begin
                     r_err <= 1'b1;
                     if (r_bad_cnt == c_ULK_W'(UNLOCK_WORDS - 1)) begin
                        r_chk_state <= ST_UNLOCKED;
                        r_lock      <= 1'b0;
                        r_bad_cnt   <= '0;
                        r_clean_cnt <= '0;
                     end else begin
                        r_bad_cnt <= r_bad_cnt + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err_cnt <= '0;
      end else if (!load_i) begin
         if (err_clr_i) begin
            r_err_cnt <= '0;
         end else if (w_chk_act && r_chk_state == ST_LOCKED && w_mism != '0) begin
            r_err_cnt <= w_sat;
         end
      end
   end

   assign tx_data_o  = r_tx_data;
   assign tx_valid_o = r_tx_valid;
   assign lock_o     = r_lock;
   assign err_o      = r_err;
   assign err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire
